// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types, EX->MEM bundle layout and pack helpers
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int EXMEM_W   = 12;
  localparam int RD_LSB    = 0;
  localparam int RD_W      = 5;
  localparam int SE_BIT    = 5;
  localparam int L_BIT     = 6;
  localparam int RF_LE_BIT = 7;
  localparam int SIZE_LSB  = 8;
  localparam int SIZE_W    = 2;
  localparam int E_BIT     = 10;
  localparam int RW_BIT    = 11;

  // Field order here fixes the bit positions: rw is the MSB, rd the LSBs.
  typedef struct packed {
    logic                rw;
    logic                e;
    logic [SIZE_W-1:0]   size;
    logic                rf_le;
    logic                l;
    logic                se;
    logic [RD_W-1:0]     rd;
  } exmem_t;

  function automatic logic [EXMEM_W-1:0] exmem_pack(input exmem_t f);
    return f;
  endfunction

  function automatic exmem_t exmem_unpack(input logic [EXMEM_W-1:0] v);
    return v;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, cleared only by reset
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic stage register with 2-entry skid, flush and stall counter
// in_ready and out_valid come straight from flops so no combinational path crosses the stage.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = EXMEM_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              w_stall;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= ST_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            r_state     <= ST_ONE;
            r_main      <= in_data;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            r_main <= in_data;
          end else if (in_valid) begin
            // Downstream stalled: park the new bundle behind main.
            r_state    <= ST_FULL;
            r_skid     <= in_data;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_main      <= RESET_VAL;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_state    <= ST_ONE;
            r_main     <= r_skid;
            r_skid     <= RESET_VAL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main      <= RESET_VAL;
          r_skid      <= RESET_VAL;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign w_stall = r_out_valid && !out_ready;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - queue-model checked bench for pipe_stage_elastic
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_ready;
  logic        in_ready,  in_ready3;
  logic        out_valid, out_valid3;
  logic [11:0] out_data,  out_data3;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt3;

  int n_checks;
  int n_fail;

  logic [11:0] mq[$];
  int          m_stall;
  int          m_stall3;

  pipe_stage_elastic #(.DATA_W(12), .RESET_VAL(12'h000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.DATA_W(12), .RESET_VAL(12'h000), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .stall_cnt(stall_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, compare DUT with model, advance model over the next rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [11:0] d, input logic r, input logic f);
    logic in_x, out_x;
    reset = rst; in_valid = v; in_data = d; out_ready = r; flush = f;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("out_data",  32'(out_data),  32'((mq.size() != 0) ? mq[0] : 12'h000));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("stall_cnt3", 32'(stall_cnt3), 32'(m_stall3));
    in_x  = v && (mq.size() < 2);
    out_x = r && (mq.size() != 0);
    if (rst) begin
      mq.delete();
      m_stall  = 0;
      m_stall3 = 0;
    end else begin
      if (mq.size() != 0 && !r) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall3 < 7) m_stall3++;
      end
      if (f) mq.delete();
      else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    exmem_t fld;
    logic [11:0] packed_v;
    n_checks = 0; n_fail = 0; m_stall = 0; m_stall3 = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 12'hABC; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // reset held with a valid input present
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h000);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    cycle(1, 1, 12'hABC, 0, 0);
    cycle(1, 1, 12'hABC, 0, 0);
    fld = '{rw: 1'b1, e: 1'b0, size: 2'd2, rf_le: 1'b1, l: 1'b0, se: 1'b1, rd: 5'h1F};
    packed_v = exmem_pack(fld);
    chk("pack", 32'(packed_v), 32'hABF);
    cycle(0, 1, packed_v, 0, 0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data",  32'(out_data),  32'hABF);
    cycle(0, 0, 12'h000, 1, 0);
    cycle(0, 0, 12'h000, 1, 0);

    // streaming
    cycle(1, 0, 12'h000, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) chk("stream_data", 32'(out_data), 32'(i - 1));
      cycle(0, 1, 12'(i), 1, 0);
    end
    chk("stream_last", 32'(out_data), 32'h008);
    cycle(0, 0, 12'h000, 1, 0);
    cycle(0, 0, 12'h000, 1, 0);

    // back-pressure
    cycle(1, 0, 12'h000, 0, 0);
    cycle(0, 1, 12'h111, 0, 0);
    cycle(0, 1, 12'h222, 0, 0);
    cycle(0, 1, 12'h333, 0, 0);
    chk("bp_in_ready", 32'(in_ready),  32'd0);
    chk("bp_data",     32'(out_data),  32'h111);
    chk("bp_stall",    32'(stall_cnt), 32'd2);
    cycle(0, 1, 12'h333, 1, 0);
    chk("bp_second", 32'(out_data), 32'h222);
    cycle(0, 1, 12'h333, 1, 0);
    chk("bp_third", 32'(out_data), 32'h333);
    cycle(0, 0, 12'h000, 1, 0);
    chk("bp_stall_end", 32'(stall_cnt), 32'd2);

    // flush while full with a simultaneous input
    cycle(1, 0, 12'h000, 0, 0);
    cycle(0, 1, 12'hAAA, 0, 0);
    cycle(0, 1, 12'hBBB, 0, 0);
    cycle(0, 1, 12'h444, 1, 1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_data",  32'(out_data),  32'h000);
    chk("fl_ready", 32'(in_ready),  32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 12'h000, 1, 0);

    // saturation of the 3-bit counter
    cycle(1, 0, 12'h000, 0, 0);
    cycle(0, 1, 12'h555, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 12'h000, 0, 0);
    chk("sat3", 32'(stall_cnt3), 32'd7);
    chk("sat16", 32'(stall_cnt), 32'd10);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), 12'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
